// File: rtl/c17_balanced_pipe.sv
// c17_balanced_pipe
//   Clocked, path-balanced implementation of the ISCAS c17 function,
//   evaluated on WIDTH independent bit-lanes. Every NAND level is
//   registered, so every input-to-output path has the same latency.
//   A valid/ready handshake with a single global stall moves vectors
//   through the pipe, and vec_count counts the results delivered.
//
// Parameters
//   WIDTH     : number of parallel bit-lanes
//   REG_SPLIT : 1'b1 -> input capture + fan-out balance stages (latency 5)
//               1'b0 -> one register per NAND level (latency 3)
//   CNT_W     : width of the delivered-vector counter
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   N1, N2, N3, N6, N7   : c17 primary inputs (one bit per lane)
//   in_valid / in_ready  : input handshake (in_ready is combinational)
//   N22, N23             : c17 primary outputs (registered)
//   out_valid / out_ready: output handshake
//   vec_count            : results delivered, wrapping
module c17_balanced_pipe #(
  parameter int WIDTH     = 32'd1,
  parameter bit REG_SPLIT = 1'b1,
  parameter int CNT_W     = 32'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] N1,
  input  logic [WIDTH-1:0] N2,
  input  logic [WIDTH-1:0] N3,
  input  logic [WIDTH-1:0] N6,
  input  logic [WIDTH-1:0] N7,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] N22,
  output logic [WIDTH-1:0] N23,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] vec_count
);

  logic             stall_s;
  logic             adv_s;
  // Values feeding the final NAND level, supplied by whichever front end is built.
  logic [WIDTH-1:0] pre_n10_s;
  logic [WIDTH-1:0] pre_n16_s;
  logic [WIDTH-1:0] pre_n19_s;
  logic             pre_valid_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] n22_r;
  logic [WIDTH-1:0] n23_r;
  logic [CNT_W-1:0] vec_count_r;

  // Global stall: a presented result that is not taken freezes the whole pipe.
  always_comb begin
    stall_s = out_valid_r && !out_ready;
    adv_s   = !stall_s;
  end

  assign in_ready = adv_s;

  if (REG_SPLIT == 1'b1) begin : g_split
    logic             s1_v_r;
    logic [WIDTH-1:0] s1_n1_r, s1_n2_r, s1_n3_r, s1_n6_r, s1_n7_r;
    logic             s2_v_r;
    logic [WIDTH-1:0] s2_n10_r, s2_n11_r, s2_n2_r, s2_n7_r;
    logic             s3_v_r;
    logic [WIDTH-1:0] s3_n11a_r, s3_n11b_r, s3_n10_r, s3_n2_r, s3_n7_r;
    logic             s4_v_r;
    logic [WIDTH-1:0] s4_n16_r, s4_n19_r, s4_n10_r;

    // S1..S4: input capture, first NAND level, N11 fan-out split, second NAND level.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v_r    <= 1'b0;
        s1_n1_r   <= {WIDTH{1'b0}};
        s1_n2_r   <= {WIDTH{1'b0}};
        s1_n3_r   <= {WIDTH{1'b0}};
        s1_n6_r   <= {WIDTH{1'b0}};
        s1_n7_r   <= {WIDTH{1'b0}};
        s2_v_r    <= 1'b0;
        s2_n10_r  <= {WIDTH{1'b0}};
        s2_n11_r  <= {WIDTH{1'b0}};
        s2_n2_r   <= {WIDTH{1'b0}};
        s2_n7_r   <= {WIDTH{1'b0}};
        s3_v_r    <= 1'b0;
        s3_n11a_r <= {WIDTH{1'b0}};
        s3_n11b_r <= {WIDTH{1'b0}};
        s3_n10_r  <= {WIDTH{1'b0}};
        s3_n2_r   <= {WIDTH{1'b0}};
        s3_n7_r   <= {WIDTH{1'b0}};
        s4_v_r    <= 1'b0;
        s4_n16_r  <= {WIDTH{1'b0}};
        s4_n19_r  <= {WIDTH{1'b0}};
        s4_n10_r  <= {WIDTH{1'b0}};
      end else if (adv_s) begin
        s1_v_r <= in_valid;
        // Data only moves with a valid token so bubbles leave registers untouched.
        if (in_valid) begin
          s1_n1_r <= N1;
          s1_n2_r <= N2;
          s1_n3_r <= N3;
          s1_n6_r <= N6;
          s1_n7_r <= N7;
        end
        s2_v_r <= s1_v_r;
        if (s1_v_r) begin
          s2_n10_r <= ~(s1_n1_r & s1_n3_r);
          s2_n11_r <= ~(s1_n3_r & s1_n6_r);
          s2_n2_r  <= s1_n2_r;
          s2_n7_r  <= s1_n7_r;
        end
        s3_v_r <= s2_v_r;
        if (s2_v_r) begin
          // Two copies of N11: one per downstream NAND (splitter stage).
          s3_n11a_r <= s2_n11_r;
          s3_n11b_r <= s2_n11_r;
          s3_n10_r  <= s2_n10_r;
          s3_n2_r   <= s2_n2_r;
          s3_n7_r   <= s2_n7_r;
        end
        s4_v_r <= s3_v_r;
        if (s3_v_r) begin
          s4_n16_r <= ~(s3_n2_r & s3_n11a_r);
          s4_n19_r <= ~(s3_n11b_r & s3_n7_r);
          s4_n10_r <= s3_n10_r;
        end
      end
    end

    assign pre_n10_s   = s4_n10_r;
    assign pre_n16_s   = s4_n16_r;
    assign pre_n19_s   = s4_n19_r;
    assign pre_valid_s = s4_v_r;
  end else begin : g_flat
    logic             s1_v_r;
    logic [WIDTH-1:0] s1_n10_r, s1_n11_r, s1_n2_r, s1_n7_r;
    logic             s2_v_r;
    logic [WIDTH-1:0] s2_n16_r, s2_n19_r, s2_n10_r;

    // S1..S2: first and second NAND levels, with N2/N7/N10 carried alongside.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v_r   <= 1'b0;
        s1_n10_r <= {WIDTH{1'b0}};
        s1_n11_r <= {WIDTH{1'b0}};
        s1_n2_r  <= {WIDTH{1'b0}};
        s1_n7_r  <= {WIDTH{1'b0}};
        s2_v_r   <= 1'b0;
        s2_n16_r <= {WIDTH{1'b0}};
        s2_n19_r <= {WIDTH{1'b0}};
        s2_n10_r <= {WIDTH{1'b0}};
      end else if (adv_s) begin
        s1_v_r <= in_valid;
        if (in_valid) begin
          s1_n10_r <= ~(N1 & N3);
          s1_n11_r <= ~(N3 & N6);
          s1_n2_r  <= N2;
          s1_n7_r  <= N7;
        end
        s2_v_r <= s1_v_r;
        if (s1_v_r) begin
          s2_n16_r <= ~(s1_n2_r & s1_n11_r);
          s2_n19_r <= ~(s1_n11_r & s1_n7_r);
          s2_n10_r <= s1_n10_r;
        end
      end
    end

    assign pre_n10_s   = s2_n10_r;
    assign pre_n16_s   = s2_n16_r;
    assign pre_n19_s   = s2_n19_r;
    assign pre_valid_s = s2_v_r;
  end

  // Final NAND level and output valid; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      n22_r       <= {WIDTH{1'b0}};
      n23_r       <= {WIDTH{1'b0}};
    end else if (adv_s) begin
      out_valid_r <= pre_valid_s;
      if (pre_valid_s) begin
        n22_r <= ~(pre_n10_s & pre_n16_s);
        n23_r <= ~(pre_n16_s & pre_n19_s);
      end
    end
  end

  // Delivered-result counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_count_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && out_ready) begin
      vec_count_r <= vec_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = out_valid_r;
  assign N22       = n22_r;
  assign N23       = n23_r;
  assign vec_count = vec_count_r;

endmodule

// File: tb/tb_c17_balanced_pipe.sv
// Bench for c17_balanced_pipe. Instance A: WIDTH=4, REG_SPLIT=1 (latency 5).
// Instance B: WIDTH=4, REG_SPLIT=0 (latency 3). Drivers push expected results
// into per-instance queues; negedge monitors pop and compare on each delivery.
module tb_c17_balanced_pipe;
  localparam int W     = 4;
  localparam int LAT_A = 5;
  localparam int LAT_B = 3;
  localparam int CW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [W-1:0]  a_n1, a_n2, a_n3, a_n6, a_n7, a_n22, a_n23;
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_vec_count;

  logic [W-1:0]  b_n1, b_n2, b_n3, b_n6, b_n7, b_n22, b_n23;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_vec_count;

  c17_balanced_pipe #(.WIDTH(W), .REG_SPLIT(1'b1), .CNT_W(CW)) u_a (
    .clk(clk), .rst(rst),
    .N1(a_n1), .N2(a_n2), .N3(a_n3), .N6(a_n6), .N7(a_n7),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .N22(a_n22), .N23(a_n23),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .vec_count(a_vec_count)
  );

  c17_balanced_pipe #(.WIDTH(W), .REG_SPLIT(1'b0), .CNT_W(CW)) u_b (
    .clk(clk), .rst(rst),
    .N1(b_n1), .N2(b_n2), .N3(b_n3), .N6(b_n6), .N7(b_n7),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .N22(b_n22), .N23(b_n23),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .vec_count(b_vec_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] n22;
    logic [W-1:0] n23;
    int           due;
    bit           lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  bit   lat_chk = 1'b1;
  bit   mon_en  = 1'b0;
  logic [CW-1:0] exp_cnt_a = 16'd0;
  logic [CW-1:0] exp_cnt_b = 16'd0;
  int   stall_cnt = 0;
  bit   prev_stall = 1'b0;
  logic [W-1:0] prev22, prev23;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [2*W-1:0] c17_ref(input logic [W-1:0] n1, n2, n3, n6, n7);
    logic [W-1:0] n10, n11, n16, n19;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // Lane l carries input combination (base + 8*l) mod 32, packed {N1,N2,N3,N6,N7}.
  task automatic mk(input int base, output logic [W-1:0] n1, n2, n3, n6, n7);
    logic [4:0] c;
    for (int l = 0; l < W; l++) begin
      c = 5'((base + 8 * l) % 32);
      n1[l] = c[4]; n2[l] = c[3]; n3[l] = c[2]; n6[l] = c[1]; n7[l] = c[0];
    end
  endtask

  task automatic issue_a(input logic [W-1:0] n1, n2, n3, n6, n7, e22, e23);
    bit ok;
    exp_t e;
    ok = 1'b0;
    a_n1 = n1; a_n2 = n2; a_n3 = n3; a_n6 = n6; a_n7 = n7;
    a_in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (a_in_ready) begin
        e.n22 = e22; e.n23 = e23; e.due = cyc + LAT_A; e.lat = lat_chk;
        qa.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    if (!ok) fail_now("a_accept");
  endtask

  task automatic issue_ref_a(input int base);
    logic [W-1:0] n1, n2, n3, n6, n7;
    logic [2*W-1:0] r;
    mk(base, n1, n2, n3, n6, n7);
    r = c17_ref(n1, n2, n3, n6, n7);
    issue_a(n1, n2, n3, n6, n7, r[2*W-1:W], r[W-1:0]);
  endtask

  task automatic issue_b(input logic [W-1:0] n1, n2, n3, n6, n7, e22, e23);
    bit ok;
    exp_t e;
    ok = 1'b0;
    b_n1 = n1; b_n2 = n2; b_n3 = n3; b_n6 = n6; b_n7 = n7;
    b_in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (b_in_ready) begin
        e.n22 = e22; e.n23 = e23; e.due = cyc + LAT_B; e.lat = 1'b1;
        qb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    if (!ok) fail_now("b_accept");
  endtask

  task automatic drain_a;
    int k;
    k = 0;
    while (qa.size() > 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (qa.size() > 0) fail_now("a_drain");
    @(posedge clk); #1;
  endtask

  task automatic drain_b;
    int k;
    k = 0;
    while (qb.size() > 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (qb.size() > 0) fail_now("b_drain");
    @(posedge clk); #1;
  endtask

  // Monitor A: counter tracking, in-order result comparison, stall hold checks.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_vec_count", 64'(a_vec_count), 64'(exp_cnt_a));
      if (rst) begin
        qa.delete();
        exp_cnt_a = 16'd0;
        prev_stall = 1'b0;
      end else if (a_out_valid && a_out_ready) begin
        chk("a_result_expected", 64'(qa.size() > 0), 64'd1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("a_n22", 64'(a_n22), 64'(ea.n22));
          chk("a_n23", 64'(a_n23), 64'(ea.n23));
          if (ea.lat) chk("a_latency", 64'(cyc), 64'(ea.due));
        end
        exp_cnt_a = exp_cnt_a + 16'd1;
        prev_stall = 1'b0;
      end else if (a_out_valid) begin
        chk("a_in_ready_stalled", 64'(a_in_ready), 64'd0);
        if (prev_stall) begin
          chk("a_n22_held", 64'(a_n22), 64'(prev22));
          chk("a_n23_held", 64'(a_n23), 64'(prev23));
        end
        stall_cnt++;
        prev_stall = 1'b1;
        prev22 = a_n22;
        prev23 = a_n23;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Monitor B: counter tracking and exact-latency result comparison.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("b_vec_count", 64'(b_vec_count), 64'(exp_cnt_b));
      if (rst) begin
        qb.delete();
        exp_cnt_b = 16'd0;
      end else if (b_out_valid && b_out_ready) begin
        chk("b_result_expected", 64'(qb.size() > 0), 64'd1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("b_n22", 64'(b_n22), 64'(eb.n22));
          chk("b_n23", 64'(b_n23), 64'(eb.n23));
          chk("b_latency", 64'(cyc), 64'(eb.due));
        end
        exp_cnt_b = exp_cnt_b + 16'd1;
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_n1 = '0; a_n2 = '0; a_n3 = '0; a_n6 = '0; a_n7 = '0;
    b_n1 = '0; b_n2 = '0; b_n3 = '0; b_n6 = '0; b_n7 = '0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("a_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_rst_n22", 64'(a_n22), 64'd0);
    chk("a_rst_n23", 64'(a_n23), 64'd0);
    chk("a_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("b_rst_out_valid", 64'(b_out_valid), 64'd0);
    chk("b_rst_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;

    // Hand-computed directed vectors
    issue_a(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    drain_a;
    chk("a_count_first", 64'(a_vec_count), 64'd1);
    issue_a(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
    // lane0 = (1,0,1,0,1) -> 1,1 ; lane1 = all ones -> 1,0 ; lanes 2/3 zero -> 0,0
    issue_a(4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0001);
    issue_b(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
    issue_b(4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0001);
    issue_b(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    drain_b;
    drain_a;
    chk("a_count_directed", 64'(a_vec_count), 64'd3);
    chk("b_count_directed", 64'(b_vec_count), 64'd3);

    // All 32 combinations back-to-back, exact latency each
    for (int i = 0; i < 32; i++) issue_ref_a(i);
    drain_a;
    chk("a_count_exhaustive", 64'(a_vec_count), 64'd35);

    // Three-cycle consumer stall with a full pipe
    lat_chk = 1'b0;
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) issue_ref_a(i * 5 + 3);
      end
      begin
        repeat (7) @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    drain_a;
    lat_chk = 1'b1;
    chk("a_stall_cycles", 64'(stall_cnt), 64'd3);
    chk("a_count_stall", 64'(a_vec_count), 64'd47);

    // Reset with three vectors in flight
    for (int i = 0; i < 3; i++) issue_ref_a(i + 11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("a_midrst_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_midrst_count", 64'(a_vec_count), 64'd0);
    chk("a_midrst_in_ready", 64'(a_in_ready), 64'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;

    // Counter wrap: 65535 transfers then one more
    for (int i = 0; i < 65535; i++) issue_ref_a(i);
    drain_a;
    chk("a_count_max", 64'(a_vec_count), 64'hFFFF);
    issue_ref_a(7);
    drain_a;
    chk("a_count_wrap", 64'(a_vec_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
